// File: rtl/img_ctrl_pkg.sv
// Shared definitions for the image-processor control block:
// op codes, depth codes, engine modes, FSM states and a display helper.
package img_ctrl_pkg;

  localparam int COORD_W = 3;   // origin / pixel coordinate width (0..7)
  localparam int CH_W    = 5;   // channel index width (0..31)
  localparam int DCNT_W  = CH_W + 2; // display counter: {channel, window index}

  // Command codes
  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_RIGHT  = 4'd1;
  localparam logic [3:0] OP_LEFT   = 4'd2;
  localparam logic [3:0] OP_UP     = 4'd3;
  localparam logic [3:0] OP_DOWN   = 4'd4;
  localparam logic [3:0] OP_DEP_DN = 4'd5;
  localparam logic [3:0] OP_DEP_UP = 4'd6;
  localparam logic [3:0] OP_DISP   = 4'd7;
  localparam logic [3:0] OP_CONV   = 4'd8;
  localparam logic [3:0] OP_MEDIAN = 4'd9;
  localparam logic [3:0] OP_SOBEL  = 4'd10;

  // Channel depth codes
  localparam logic [1:0] DEP_8  = 2'd0;
  localparam logic [1:0] DEP_16 = 2'd1;
  localparam logic [1:0] DEP_32 = 2'd2;

  // Engine mode codes
  localparam logic [1:0] ENG_CONV   = 2'd0;
  localparam logic [1:0] ENG_MEDIAN = 2'd1;
  localparam logic [1:0] ENG_SOBEL  = 2'd2;

  typedef enum logic [2:0] {
    S_READY,
    S_WAIT,
    S_LOAD,
    S_DISP,
    S_ENG_START,
    S_ENG_WAIT
  } state_t;

  // Last display counter value: 4 reads per channel, (8 << dep) channels.
  function automatic logic [DCNT_W-1:0] disp_last(input logic [1:0] dep);
    case (dep)
      DEP_8:   disp_last = DCNT_W'(31);
      DEP_16:  disp_last = DCNT_W'(63);
      default: disp_last = DCNT_W'(127);
    endcase
  endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Display address generator: maps origin, 2x2 window index and channel
// onto the SRAM layout {ch, row, col}. Purely combinational.
module img_addr_gen
  import img_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [1:0]         win,
  input  logic [CH_W-1:0]    ch,
  output logic [ADDR_W-1:0]  addr
);

  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  // Window bit 1 selects the lower row, bit 0 the right column.
  always_comb begin
    row  = origin_y + COORD_W'(win[1]);
    col  = origin_x + COORD_W'(win[0]);
    addr = ADDR_W'({ch, row, col});
  end

endmodule

// File: rtl/img_op_ctrl.sv
// Top-level sequencer for the image-processor core: accepts op commands,
// runs the image load, tracks window origin / channel depth, sequences
// display reads and starts/awaits the compute engine.
// Optional macro IMG_CTRL_OPCNT_EN adds o_op_cnt, a count of accepted commands.
module img_op_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int IMG_DIM = 8,
  parameter int CH_MAX  = 32,
  parameter int ADDR_W  = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  input  logic [3:0]        i_op_mode,
  output logic              o_op_ready,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_sram_we,
  output logic              o_sram_re,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_eng_start,
  output logic [1:0]        o_eng_mode,
  input  logic              i_eng_done,
  output logic [2:0]        o_origin_x,
  output logic [2:0]        o_origin_y,
  output logic [1:0]        o_depth
`ifdef IMG_CTRL_OPCNT_EN
  ,
  output logic [15:0]       o_op_cnt
`endif
);

  localparam logic [COORD_W-1:0] ORG_MAX   = COORD_W'(IMG_DIM - 2);
  localparam logic [ADDR_W-1:0]  LOAD_LAST = ADDR_W'(CH_MAX * IMG_DIM * IMG_DIM - 1);

  state_t              state;
  logic [ADDR_W-1:0]   load_cnt;
  logic [DCNT_W-1:0]   disp_cnt;
  logic [ADDR_W-1:0]   disp_addr;
  logic                accept;

  assign accept = (state == S_WAIT) && i_op_valid;

  img_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .origin_x(o_origin_x),
    .origin_y(o_origin_y),
    .win     (disp_cnt[1:0]),
    .ch      (disp_cnt[DCNT_W-1:2]),
    .addr    (disp_addr)
  );

  // Main sequencer: state, counters, origin, depth and engine mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_READY;
      load_cnt   <= '0;
      disp_cnt   <= '0;
      o_origin_x <= '0;
      o_origin_y <= '0;
      o_depth    <= DEP_32;
      o_eng_mode <= ENG_CONV;
    end else begin
      case (state)
        S_READY: state <= S_WAIT;
        S_WAIT: begin
          if (accept) begin
            state <= S_READY;
            case (i_op_mode)
              OP_LOAD: begin
                load_cnt <= '0;
                state    <= S_LOAD;
              end
              OP_RIGHT:  if (o_origin_x != ORG_MAX) o_origin_x <= o_origin_x + 3'd1;
              OP_LEFT:   if (o_origin_x != '0)      o_origin_x <= o_origin_x - 3'd1;
              OP_UP:     if (o_origin_y != '0)      o_origin_y <= o_origin_y - 3'd1;
              OP_DOWN:   if (o_origin_y != ORG_MAX) o_origin_y <= o_origin_y + 3'd1;
              OP_DEP_DN: if (o_depth != DEP_8)      o_depth    <= o_depth - 2'd1;
              OP_DEP_UP: if (o_depth != DEP_32)     o_depth    <= o_depth + 2'd1;
              OP_DISP: begin
                disp_cnt <= '0;
                state    <= S_DISP;
              end
              OP_CONV: begin
                o_eng_mode <= ENG_CONV;
                state      <= S_ENG_START;
              end
              OP_MEDIAN: begin
                o_eng_mode <= ENG_MEDIAN;
                state      <= S_ENG_START;
              end
              OP_SOBEL: begin
                o_eng_mode <= ENG_SOBEL;
                state      <= S_ENG_START;
              end
              default: ; // illegal op: no state change besides returning to READY
            endcase
          end
        end
        S_LOAD: begin
          if (i_in_valid) begin
            load_cnt <= load_cnt + ADDR_W'(1);
            if (load_cnt == LOAD_LAST) state <= S_READY;
          end
        end
        S_DISP: begin
          if (disp_cnt == disp_last(o_depth)) state <= S_READY;
          else disp_cnt <= disp_cnt + DCNT_W'(1);
        end
        S_ENG_START: state <= S_ENG_WAIT; // engine done is not looked at here
        S_ENG_WAIT:  if (i_eng_done) state <= S_READY;
        default:     state <= S_READY;
      endcase
    end
  end

  // Strobes decode the state register; ready is masked while reset is held
  // so it is low in reset yet high in the first cycle after release.
  always_comb begin
    o_op_ready  = (state == S_READY) && !i_rst;
    o_in_ready  = (state == S_LOAD);
    o_sram_we   = i_in_valid && o_in_ready;
    o_sram_re   = (state == S_DISP);
    o_eng_start = (state == S_ENG_START);
    o_sram_addr = '0;
    if (state == S_LOAD) o_sram_addr = load_cnt;
    else if (state == S_DISP) o_sram_addr = disp_addr;
  end

`ifdef IMG_CTRL_OPCNT_EN
  // Count every accepted command, illegal ones included; wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_op_cnt <= '0;
    else if (accept) o_op_cnt <= o_op_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_img_op_ctrl.sv
// Directed testbench for img_op_ctrl.
module tb_img_op_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op_mode = 4'd0;
  logic        op_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sram_we;
  logic        sram_re;
  logic [10:0] sram_addr;
  logic        eng_start;
  logic [1:0]  eng_mode;
  logic        eng_done = 1'b0;
  logic [2:0]  origin_x;
  logic [2:0]  origin_y;
  logic [1:0]  depth;
`ifdef IMG_CTRL_OPCNT_EN
  logic [15:0] op_cnt;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  img_op_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_op_valid (op_valid),
    .i_op_mode  (op_mode),
    .o_op_ready (op_ready),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .o_sram_we  (sram_we),
    .o_sram_re  (sram_re),
    .o_sram_addr(sram_addr),
    .o_eng_start(eng_start),
    .o_eng_mode (eng_mode),
    .i_eng_done (eng_done),
    .o_origin_x (origin_x),
    .o_origin_y (origin_y),
    .o_depth    (depth)
`ifdef IMG_CTRL_OPCNT_EN
    ,
    .o_op_cnt   (op_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one command for a single edge; caller must be in WAIT.
  task automatic send_op(input logic [3:0] m);
    op_valid = 1'b1;
    op_mode  = m;
    step();
    op_valid = 1'b0;
  endtask

  // Command that should return to READY right after acceptance.
  task automatic quick_op(input logic [3:0] m, input string tag);
    send_op(m);
    #1 check(tag, op_ready, 1);
    step();
  endtask

  initial begin
    int writes, bad_addr, bad_we, bad_rdy, c, nr, rdy_c, nrdy, nst;
    logic [10:0] rd [128];
    logic [10:0] exp_a;

    // ---------------- reset values ----------------
    step(); step();
    #1;
    check("rst_op_ready", op_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sram_re", sram_re, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_mode", eng_mode, 0);
    check("rst_origin", {origin_x, origin_y}, 0);
    check("rst_depth", depth, 2);
    rst = 1'b0;
    #1 check("first_ready", op_ready, 1);
    step();
    check("ready_one_cycle", op_ready, 0);

    // ---------------- load with a 10-cycle stall ----------------
    send_op(4'd0);
    writes = 0; bad_addr = 0; bad_we = 0; bad_rdy = 0; c = 0;
    while (writes < 2048 && c < 3000) begin
      in_valid = !(c >= 100 && c <= 109);
      #1;
      if (!in_ready || op_ready) bad_rdy++;
      if (sram_we !== in_valid) bad_we++;
      if (sram_addr !== 11'(writes)) bad_addr++;
      if (c == 105) begin
        check("stall_no_write", sram_we, 0);
        check("stall_addr_hold", sram_addr, 100);
      end
      if (sram_we) writes++;
      step();
      c++;
    end
    in_valid = 1'b0;
    check("load_writes", writes, 2048);
    check("load_cycles", c, 2058);
    check("load_addr_seq", bad_addr, 0);
    check("load_we", bad_we, 0);
    check("load_in_ready", bad_rdy, 0);
    #1;
    check("load_done_ready", op_ready, 1);
    check("load_done_in_ready", in_ready, 0);
    check("load_done_we", sram_we, 0);
    step();
    check("load_ready_single", op_ready, 0);

    // ---------------- origin shifts with clamping ----------------
    quick_op(4'd2, "left_ready");
    quick_op(4'd3, "up_ready");
    check("clamp_00", {origin_x, origin_y}, 0);
    for (int i = 0; i < 7; i++) quick_op(4'd1, "right_ready");
    check("x_after_7_right", origin_x, 6);
    quick_op(4'd1, "right8_ready");
    check("x_clamp_6", origin_x, 6);
    for (int i = 0; i < 5; i++) quick_op(4'd2, "left_ready");
    quick_op(4'd4, "down_ready");
    quick_op(4'd4, "down_ready");
    check("origin_1_2", {origin_x, origin_y}, {3'd1, 3'd2});

    // ---------------- depth down and display ----------------
    quick_op(4'd5, "dep_dn_ready");
    quick_op(4'd5, "dep_dn_ready");
    check("depth_8", depth, 0);
    quick_op(4'd5, "dep_dn_clamp_ready");
    check("depth_clamp_8", depth, 0);
    send_op(4'd7);
    nr = 0; rdy_c = -1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (op_ready) begin
        rdy_c = k;
        break;
      end
      if (sram_re && nr < 128) begin
        rd[nr] = sram_addr;
        nr++;
      end
      step();
    end
    check("disp_reads", nr, 32);
    check("disp_ready_cycle", rdy_c, 32);
    check("disp_a0", rd[0], 17);
    check("disp_a1", rd[1], 18);
    check("disp_a2", rd[2], 25);
    check("disp_a3", rd[3], 26);
    check("disp_a4", rd[4], 81);
    bad_addr = 0;
    for (int i = 0; i < 32 && i < nr; i++) begin
      exp_a = 11'((i / 4) * 64 + (2 + (i % 4) / 2) * 8 + (1 + (i % 2)));
      if (rd[i] !== exp_a) bad_addr++;
    end
    check("disp_addr_seq", bad_addr, 0);
    step();

    // ---------------- convolution with delayed done ----------------
    send_op(4'd8);
    #1;
    check("conv_start", eng_start, 1);
    check("conv_mode", eng_mode, 0);
    eng_done = 1'b1;   // must be ignored in the start cycle
    step();
    eng_done = 1'b0;
    #1;
    check("conv_start_pulse", eng_start, 0);
    check("conv_early_done_ignored", op_ready, 0);
    nrdy = 0; nst = 0;
    for (int k = 0; k < 50; k++) begin
      if (op_ready) nrdy++;
      if (eng_start) nst++;
      step();
      #1;
    end
    check("conv_wait_no_ready", nrdy, 0);
    check("conv_wait_no_start", nst, 0);
    check("conv_origin_hold", {origin_x, origin_y, depth}, {3'd1, 3'd2, 2'd0});
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    #1 check("conv_done_ready", op_ready, 1);
    step();

    // ---------------- sobel mode ----------------
    send_op(4'd10);
    #1;
    check("sobel_start", eng_start, 1);
    check("sobel_mode", eng_mode, 2);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    #1 check("sobel_done_ready", op_ready, 1);
    check("sobel_mode_hold", eng_mode, 2);

    // ---------------- illegal op, ignored strobe outside WAIT ----------------
    step();
    send_op(4'd13);
    #1;
    check("illegal_ready", op_ready, 1);
    check("illegal_no_change", {origin_x, origin_y, depth, in_ready, sram_re, eng_start},
          {3'd1, 3'd2, 2'd0, 3'd0});
    op_valid = 1'b1;   // presented during READY: must be ignored
    op_mode  = 4'd1;
    step();
    op_valid = 1'b0;
    step();
    check("valid_outside_wait", origin_x, 1);

    // ---------------- depth up, reset mid-display ----------------
    quick_op(4'd6, "dep_up_ready");
    check("depth_16", depth, 1);
    send_op(4'd7);
    step(); step();
    #1 check("disp_active", sram_re, 1);
    rst = 1'b1;
    #1;
    check("rst_async_re", sram_re, 0);
    check("rst_async_addr", sram_addr, 0);
    check("rst_async_origin", {origin_x, origin_y}, 0);
    check("rst_async_depth", depth, 2);
    check("rst_async_ready", op_ready, 0);
    step(); step();
    rst = 1'b0;
    #1 check("post_rst_ready", op_ready, 1);
    step();
    check("post_rst_ready_gone", op_ready, 0);
    check("post_rst_origin", {origin_x, origin_y, depth}, {3'd0, 3'd0, 2'd2});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/img_op_ctrl.md
Name: img_op_ctrl

Overview:
- Top-level sequencer for the image-processor core.
- Accepts 4-bit op commands over the op handshake, runs the 2048-byte image load, and tracks display state: 2x2 window origin and channel depth.
- Generates SRAM read/write addresses and sequences display reads.
- Starts and awaits the compute engine for convolution, median and Sobel/NMS ops.
- The engine owns o_out_valid/o_out_data; this block only schedules it.

Parameters:
- IMG_DIM, 8, image width and height in pixels (8x8).
- CH_MAX, 32, number of stored channels.
- ADDR_W, 11, SRAM address width (CH_MAX*IMG_DIM*IMG_DIM = 2048 bytes).

Ports:
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_op_valid  in  1  one-cycle command strobe.
- i_op_mode  in  4  command code, sampled with i_op_valid.
- o_op_ready  out  1  one-cycle pulse: ready for the next command.
- i_in_valid  in  1  image byte valid during load.
- o_in_ready  out  1  high while in LOAD.
- o_sram_we  out  1  write enable; equals i_in_valid && o_in_ready.
- o_sram_re  out  1  display read issue.
- o_sram_addr  out  ADDR_W  addr = ch*64 + row*8 + col.
- o_eng_start  out  1  one-cycle engine start pulse.
- o_eng_mode  out  2  0=conv, 1=median, 2=sobel_nms; held stable through the op.
- i_eng_done  in  1  engine completion strobe.
- o_origin_x  out  3  window column, 0..6.
- o_origin_y  out  3  window row, 0..6.
- o_depth  out  2  0=8 channels, 1=16 channels, 2=32 channels.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All strobes and enables 0; o_sram_addr 0; o_eng_mode 0.
  - Origin (0,0); o_depth 2 (32 channels); state READY.
- State machine: READY -> WAIT -> {LOAD | DISP | ENG_START -> ENG_WAIT | READY}.
  - READY: exactly one cycle, o_op_ready=1, then WAIT.
  - First READY is the first cycle after i_rst deasserts.
  - WAIT: a command is accepted only here, on i_op_valid=1. i_op_valid in any other state is ignored.
- Op codes:
  - 0 load: go to LOAD.
  - 1 right, 2 left, 3 up, 4 down: shift origin by 1.
  - 5 depth down (32->16->8), 6 depth up (8->16->32).
  - 7 display.
  - 8 conv, 9 median, 10 sobel_nms.
  - 11..15 illegal.
- Shift, depth and illegal ops:
  - Register update on the acceptance edge; READY in the next cycle.
  - Accept at cycle T gives o_op_ready at T+1.
  - Shift clamps at the edges: no change if x or y is already 0 (left/up) or 6 (right/down).
  - Depth clamps at 8 and 32.
  - Illegal ops: no state change.
- LOAD:
  - o_in_ready=1; internal 11-bit counter starts at 0.
  - Each cycle with i_in_valid=1 writes at the counter address, then increments.
  - i_in_valid=0 stalls the counter (no write, no exit).
  - After beat 2047 is written, go to READY and drop o_in_ready.
- DISP:
  - 4*depth consecutive cycles of o_sram_re=1.
  - Order: for ch = 0..depth-1, emit (y,x), (y,x+1), (y+1,x), (y+1,x+1).
  - Then READY.
- ENG:
  - ENG_START drives o_eng_start for one cycle with o_eng_mode set.
  - ENG_WAIT waits for i_eng_done. i_eng_done during ENG_START is ignored.
  - On done, READY next cycle.
  - o_origin_x/y and o_depth stay constant during ENG.
- Reset mid-operation: abort immediately; all outputs return to reset values.
  - Partially loaded SRAM content is left as is and is not tracked.

Optional Feature:
- IMG_CTRL_OPCNT_EN defined:
  - Adds output o_op_cnt [15:0], reset 0.
  - Increments on every accepted command, illegal ones included; wraps at 0xFFFF -> 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package img_ctrl_pkg holds:
  - Op code localparams (OP_LOAD..OP_SOBEL).
  - Depth codes DEP_8/16/32.
  - FSM state encoding.
  - Engine mode codes.
- One natural sub-module, img_addr_gen: combinational address = {ch, row, col} from origin, window index (0..3) and channel counter.
  - The counters stay in img_op_ctrl.

Test Plan:
- Reset, then op 0 with 2048 bytes -> o_in_ready for 2048 valid beats, addresses 0..2047 in order, single o_op_ready pulse afterwards.
- Load with i_in_valid low for cycles 100..109 -> no writes, counter holds at 100, load ends after exactly 2048 writes.
- From origin (0,0): op 2 then op 3 -> origin stays (0,0). Seven op 1 -> x=6; an eighth op 1 -> x stays 6.
- Op 5 twice then op 7 -> 32 reads. With origin (1,2), the first four addresses are 17, 18, 25, 26 and the fifth is 81.
- Op 8 -> one o_eng_start with mode 0. i_eng_done held off 50 cycles -> no o_op_ready until 1 cycle after done. Op 13 -> o_op_ready next cycle, no state change.
- Assert i_rst mid-DISP -> o_sram_re drops asynchronously. After release: origin (0,0), depth 32, o_op_ready pulse on the first cycle.
